// File: rtl/fetch_unit.sv
// ============================================================================
// Module      : fetch_unit
// Description : Single-entry instruction fetch stage with redirect and stall.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] pc_addr,
    input  logic [31:0] instr_in,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4,
    output logic        misalign_err,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_pc_plus4_q, out_pc_plus4_d;
    logic        misalign_err_q, misalign_err_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        out_valid_d    = out_valid_q;
        out_instr_d    = out_instr_q;
        out_pc_d       = out_pc_q;
        out_pc_plus4_d = out_pc_plus4_q;
        misalign_err_d = misalign_err_q;
        fetch_count_d  = fetch_count_q;

        // A handshake counts even when a redirect flushes the slot this cycle.
        if (out_valid_q && out_ready) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end

        if (state_q == BOOT) begin
            state_d = RUN;
        end else if (redirect_valid) begin
            out_valid_d = 1'b0;
            if (redirect_target[1:0] == 2'b00) begin
                pc_d    = redirect_target;
                state_d = RUN;
            end else begin
                misalign_err_d = 1'b1;
                state_d        = HALT;
            end
        end else if (state_q == RUN && (!out_valid_q || out_ready)) begin
            out_instr_d    = instr_in;
            out_pc_d       = pc_q;
            out_pc_plus4_d = pc_q + 32'd4;
            out_valid_d    = 1'b1;
            pc_d           = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= BOOT;
            pc_q           <= RESET_PC;
            out_valid_q    <= 1'b0;
            out_instr_q    <= 32'd0;
            out_pc_q       <= 32'd0;
            out_pc_plus4_q <= 32'd0;
            misalign_err_q <= 1'b0;
            fetch_count_q  <= 32'd0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            out_valid_q    <= out_valid_d;
            out_instr_q    <= out_instr_d;
            out_pc_q       <= out_pc_d;
            out_pc_plus4_q <= out_pc_plus4_d;
            misalign_err_q <= misalign_err_d;
            fetch_count_q  <= fetch_count_d;
        end
    end

    assign pc_addr      = pc_q;
    assign out_valid    = out_valid_q;
    assign out_instr    = out_instr_q;
    assign out_pc       = out_pc_q;
    assign out_pc_plus4 = out_pc_plus4_q;
    assign misalign_err = misalign_err_q;
    assign fetch_count  = fetch_count_q;

endmodule

`default_nettype wire
